// File: rtl/scr1_memif_pkg.sv
// SCR1 memory-interface encodings shared by the core ports and every
// memory-side responder. These mirror the core's memif typedefs exactly.
package scr1_memif_pkg;

  // Access direction.
  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  // Access size. 2'b11 is not a legal size and is answered with an error.
  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  // Response code, driven by the target for one cycle per access.
  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

endpackage

// File: rtl/ssrv_mem_pkg.sv
// Constants shared by the ssrv memory responders (dmem now, imem later):
// base byte-enable patterns, FSM state encoding and a width-to-enable helper.
package ssrv_mem_pkg;

  import scr1_memif_pkg::*;

  // Byte-enable patterns for a lane-0 access; shifted left by addr[1:0].
  localparam logic [3:0] BE_BYTE  = 4'b0001;
  localparam logic [3:0] BE_HWORD = 4'b0011;
  localparam logic [3:0] BE_WORD  = 4'b1111;

  // Largest wait-state count the 4-bit countdown can hold.
  localparam int unsigned LATENCY_MAX = 15;

  // Responder FSM state encoding (also exposed on the debug port).
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Unshifted byte enables for an access width; illegal widths enable nothing.
  function automatic logic [3:0] be_base(input type_scr1_mem_width_e width);
    case (width)
      SCR1_MEM_WIDTH_BYTE:  be_base = BE_BYTE;
      SCR1_MEM_WIDTH_HWORD: be_base = BE_HWORD;
      SCR1_MEM_WIDTH_WORD:  be_base = BE_WORD;
      default:              be_base = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ssrv_mem_lane_align.sv
// Byte-lane steering for a 32-bit little-endian memory word: byte enables,
// write-data placement, read-data extraction and the misalignment flag, all
// derived from the access width and the low two address bits.
module ssrv_mem_lane_align
  import scr1_memif_pkg::*;
  import ssrv_mem_pkg::*;
(
  input  type_scr1_mem_width_e width,
  input  logic [1:0]           addr_lo,
  input  logic [31:0]          wdata,
  input  logic [31:0]          rword,
  output logic [3:0]           be,
  output logic [31:0]          wdata_sh,
  output logic [31:0]          rdata_sh,
  output logic                 misaligned
);

  logic [4:0] shamt;

  assign shamt = {addr_lo, 3'b000};

  // Lane placement: write data moves up to its lanes, read data moves down to
  // bit 0 with the upper bits left raw (the LSU does any sign extension).
  always_comb begin
    be       = be_base(width) << addr_lo;
    wdata_sh = wdata << shamt;
    rdata_sh = rword >> shamt;
  end

  // Natural alignment per width; the reserved width encoding always flags.
  always_comb begin
    misaligned = 1'b0;
    case (width)
      SCR1_MEM_WIDTH_BYTE:  misaligned = 1'b0;
      SCR1_MEM_WIDTH_HWORD: misaligned = addr_lo[0];
      SCR1_MEM_WIDTH_WORD:  misaligned = |addr_lo;
      default:              misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/ssrv_dmem_responder.sv
// SCR1 DMEM target: word-addressed local RAM answering core requests after a
// fixed number of wait states. Misaligned, out-of-range and illegal-width
// accesses complete with RDY_ER and leave the RAM untouched.
//
// Handshake: a request is accepted in any cycle where dmem_req and
// dmem_req_ack are both high at the rising edge; the inputs are sampled only
// then. dmem_req_ack is high in IDLE and RESP (so back-to-back accesses run
// at one per LATENCY+1 cycles) and low while waiting. The response appears on
// dmem_resp for exactly one cycle, LATENCY+1 cycles after the accept cycle;
// dmem_rdata is meaningful only alongside RDY_OK.
module ssrv_dmem_responder
  import scr1_memif_pkg::*;
  import ssrv_mem_pkg::*;
#(
  parameter int              AWIDTH     = 32,
  parameter int              DWIDTH     = 32,
  parameter int              DEPTH_LOG2 = 12,
  parameter logic [AWIDTH-1:0] BASE_ADDR = {AWIDTH{1'b0}},
  parameter int              LATENCY    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dmem_req,
  input  type_scr1_mem_cmd_e   dmem_cmd,
  input  type_scr1_mem_width_e dmem_width,
  input  logic [AWIDTH-1:0]    dmem_addr,
  input  logic [DWIDTH-1:0]    dmem_wdata,
  output logic                 dmem_req_ack,
  output logic [DWIDTH-1:0]    dmem_rdata,
  output type_scr1_mem_resp_e  dmem_resp,
  output logic [1:0]           dbg_state
);

  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  // FSM and countdown
  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [3:0] cnt_q;
  logic       accept;
  logic       enter_resp;

  // Request fields captured on accept
  type_scr1_mem_cmd_e   cmd_q;
  type_scr1_mem_width_e width_q;
  logic [AWIDTH-1:0]    addr_q;
  logic [DWIDTH-1:0]    wdata_q;

  // Fields of the access being completed at the edge entering RESP. With no
  // wait states that edge is the accept edge itself, so the live inputs are
  // used; otherwise the captured copy is.
  type_scr1_mem_cmd_e   cmd_e;
  type_scr1_mem_width_e width_e;
  logic [AWIDTH-1:0]    addr_e;
  logic [DWIDTH-1:0]    wdata_e;
  logic [AWIDTH-1:0]    off_e;
  logic [DEPTH_LOG2-1:0] idx_e;

  // Checks and lane steering
  logic        range_err;
  logic        misaligned;
  logic        access_err;
  logic        ram_we;
  logic [3:0]  be;
  logic [31:0] wdata_sh;
  logic [31:0] rdata_sh;
  logic [31:0] rword;

  // Response registers
  logic              err_q;
  logic [DWIDTH-1:0] rdata_q;

  // Storage; deliberately not reset
  logic [31:0] mem [DEPTH];

  assign accept     = dmem_req & dmem_req_ack;
  assign enter_resp = (state_d == ST_RESP);
  assign dbg_state  = state_q;

  assign cmd_e   = (LATENCY == 0) ? dmem_cmd   : cmd_q;
  assign width_e = (LATENCY == 0) ? dmem_width : width_q;
  assign addr_e  = (LATENCY == 0) ? dmem_addr  : addr_q;
  assign wdata_e = (LATENCY == 0) ? dmem_wdata : wdata_q;

  // Index is taken from the base-relative offset; it is only used once the
  // range check has passed, so truncation never aliases.
  assign off_e = addr_e - BASE_ADDR;
  assign idx_e = off_e[DEPTH_LOG2+1:2];

  assign range_err  = (addr_e < BASE_ADDR) | ((off_e >> (DEPTH_LOG2 + 2)) != '0);
  assign access_err = range_err | misaligned;
  assign ram_we     = enter_resp & ~access_err & (cmd_e == SCR1_MEM_CMD_WR);
  assign rword      = mem[idx_e];

  ssrv_mem_lane_align u_lane_align (
    .width      (width_e),
    .addr_lo    (addr_e[1:0]),
    .wdata      (wdata_e),
    .rword      (rword),
    .be         (be),
    .wdata_sh   (wdata_sh),
    .rdata_sh   (rdata_sh),
    .misaligned (misaligned)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: IDLE and RESP both accept; a zero-latency accept goes
  // straight to RESP, otherwise WAIT counts down to zero first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: ready whenever not waiting (and not in reset); response code is
  // presented only during the single RESP cycle.
  always_comb begin
    dmem_req_ack = rst_n & ((state_q == ST_IDLE) | (state_q == ST_RESP));
    dmem_resp    = SCR1_MEM_RESP_NOTRDY;
    if (state_q == ST_RESP) begin
      dmem_resp = err_q ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
    end
    dmem_rdata = rdata_q;
  end

  // Capture request fields on accept and run the wait-state countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 4'd0;
      cmd_q   <= SCR1_MEM_CMD_RD;
      width_q <= SCR1_MEM_WIDTH_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      cnt_q   <= LAT_M1;
      cmd_q   <= dmem_cmd;
      width_q <= dmem_width;
      addr_q  <= dmem_addr;
      wdata_q <= dmem_wdata;
    end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Response data and status, updated on the edge entering RESP. Errors
  // return zero; write completions keep the previous read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (enter_resp) begin
      err_q <= access_err;
      if (access_err) begin
        rdata_q <= '0;
      end else if (cmd_e == SCR1_MEM_CMD_RD) begin
        rdata_q <= rdata_sh;
      end
    end
  end

  // Byte-masked RAM write on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx_e][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ssrv_dmem_responder.sv
// Bench for ssrv_dmem_responder. Three instances share one clock:
//   0: LATENCY=0, 4K words at base 0
//   1: LATENCY=0, 16 words at base 0x1000
//   2: LATENCY=3, 4K words at base 0
// A byte-level reference memory and a queue of pending accesses predict
// req_ack, resp and rdata for every instance on every cycle.
module tb_ssrv_dmem_responder;

  import scr1_memif_pkg::*;

  localparam int NI = 3;
  localparam int EW = 101;  // {due[31:0], inst[1:0], cmd, width[1:0], addr[31:0], wdata[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n [NI];
  logic                 req   [NI];
  type_scr1_mem_cmd_e   cmd   [NI];
  type_scr1_mem_width_e wid   [NI];
  logic [31:0]          addr  [NI];
  logic [31:0]          wdata [NI];
  logic                 ack   [NI];
  logic [31:0]          rdata [NI];
  type_scr1_mem_resp_e  resp  [NI];
  logic [1:0]           dbg   [NI];

  ssrv_dmem_responder #(.LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .dmem_req(req[0]), .dmem_cmd(cmd[0]),
    .dmem_width(wid[0]), .dmem_addr(addr[0]), .dmem_wdata(wdata[0]),
    .dmem_req_ack(ack[0]), .dmem_rdata(rdata[0]), .dmem_resp(resp[0]),
    .dbg_state(dbg[0])
  );

  ssrv_dmem_responder #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0000_1000), .LATENCY(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .dmem_req(req[1]), .dmem_cmd(cmd[1]),
    .dmem_width(wid[1]), .dmem_addr(addr[1]), .dmem_wdata(wdata[1]),
    .dmem_req_ack(ack[1]), .dmem_rdata(rdata[1]), .dmem_resp(resp[1]),
    .dbg_state(dbg[1])
  );

  ssrv_dmem_responder #(.LATENCY(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]), .dmem_req(req[2]), .dmem_cmd(cmd[2]),
    .dmem_width(wid[2]), .dmem_addr(addr[2]), .dmem_wdata(wdata[2]),
    .dmem_req_ack(ack[2]), .dmem_rdata(rdata[2]), .dmem_resp(resp[2]),
    .dbg_state(dbg[2])
  );

  // ---------------- reference model state ----------------
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cyc_n        = 0;
  int          busy_due [NI];
  logic [31:0] exp_rdata [NI];
  bit          exp_rdata_known [NI];
  logic [7:0]  mm [longint];
  logic [EW-1:0] exp_q [$];
  logic [31:0] saved_word;

  function automatic int lat_of(input int i);
    return (i == 2) ? 3 : 0;
  endfunction

  function automatic logic [31:0] base_of(input int i);
    return (i == 1) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  function automatic logic [31:0] depth_of(input int i);
    return (i == 1) ? 32'd16 : 32'd4096;
  endfunction

  function automatic longint key_of(input int i, input logic [31:0] a);
    return (longint'(i) << 32) | longint'(a);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s[%0d] cyc %0d: got %h expected %h", tag, i, cyc_n, obs, exp);
    end
  endtask

  // Complete one access against the byte memory: decide OK/ER from the
  // address rules, apply writes, and compute the expected read data.
  task automatic retire(input logic [EW-1:0] e, output type_scr1_mem_resp_e r);
    int          i;
    int          nb;
    bit          err;
    bit          known;
    logic        wr;
    logic [1:0]  w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    i  = int'(e[68:67]);
    wr = e[66];
    w  = e[65:64];
    a  = e[63:32];
    d  = e[31:0];
    case (w)
      2'd0:    nb = 1;
      2'd1:    nb = 2;
      2'd2:    nb = 4;
      default: nb = 0;
    endcase
    err = (nb == 0);
    if (!err) err = ((a % nb) != 0);
    if (a < base_of(i)) err = 1'b1;
    else if (((a - base_of(i)) / 4) >= depth_of(i)) err = 1'b1;
    if (err) begin
      r = SCR1_MEM_RESP_RDY_ER;
      exp_rdata[i] = 32'h0;
      exp_rdata_known[i] = 1'b1;
    end else begin
      r = SCR1_MEM_RESP_RDY_OK;
      if (wr) begin
        for (int k = 0; k < nb; k++) mm[key_of(i, a + k)] = d[8*k +: 8];
      end else begin
        rd = 32'h0;
        known = 1'b1;
        for (int k = 0; k < 4 - int'(a % 4); k++) begin
          if (mm.exists(key_of(i, a + k))) rd = rd | ({24'h0, mm[key_of(i, a + k)]} << (8 * k));
          else known = 1'b0;
        end
        exp_rdata[i] = rd;
        exp_rdata_known[i] = known;
      end
    end
  endtask

  // Per-cycle check of every instance, taken mid-cycle at the falling edge.
  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      type_scr1_mem_resp_e er;
      logic exp_ack;
      er = SCR1_MEM_RESP_NOTRDY;
      for (int q = 0; q < exp_q.size(); q++) begin
        if ((int'(exp_q[q][68:67]) == i) && (int'(exp_q[q][100:69]) == cyc_n)) begin
          retire(exp_q[q], er);
          exp_q.delete(q);
          break;
        end
      end
      exp_ack = rst_n[i] && (cyc_n >= busy_due[i]);
      chk("req_ack", i, 32'(ack[i]), 32'(exp_ack));
      chk("resp", i, 32'(resp[i]), 32'(er));
      if (exp_rdata_known[i]) chk("rdata", i, rdata[i], exp_rdata[i]);
    end
  endtask

  // Record the accesses the model says are taken this cycle.
  task automatic commit();
    for (int i = 0; i < NI; i++) begin
      if (rst_n[i] && req[i] && (cyc_n >= busy_due[i])) begin
        busy_due[i] = cyc_n + lat_of(i) + 1;
        exp_q.push_back({32'(busy_due[i]), 2'(i), cmd[i], wid[i], addr[i], wdata[i]});
      end
    end
  endtask

  task automatic cyc();
    commit();
    @(posedge clk);
    cyc_n++;
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_n(input int n);
    repeat (n) cyc();
  endtask

  // ---------------- drivers ----------------
  task automatic access(input int i, input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                        input logic [31:0] a, input logic [31:0] d);
    req[i] = 1'b1; cmd[i] = c; wid[i] = w; addr[i] = a; wdata[i] = d;
    cyc();
    req[i] = 1'b0;
  endtask

  task automatic purge(input int i);
    for (int q = exp_q.size() - 1; q >= 0; q--) begin
      if (int'(exp_q[q][68:67]) == i) exp_q.delete(q);
    end
    busy_due[i] = 0;
    exp_rdata[i] = 32'h0;
    exp_rdata_known[i] = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr(input int i);
    logic [31:0] a;
    bit oor;
    oor = ($urandom_range(0, 9) == 0);
    case (i)
      0:       a = oor ? 32'h0000_4000 + $urandom_range(0, 63) : 32'h0000_0100 + $urandom_range(0, 63);
      1:       a = oor ? (($urandom_range(0, 1) == 1) ? 32'h0000_0FF0 + $urandom_range(0, 15)
                                                      : 32'h0000_1040 + $urandom_range(0, 15))
                       : 32'h0000_1000 + $urandom_range(0, 63);
      default: a = oor ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : 32'h0000_0200 + $urandom_range(0, 31);
    endcase
    return a;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b1; req[i] = 1'b0; cmd[i] = SCR1_MEM_CMD_RD;
      wid[i] = SCR1_MEM_WIDTH_WORD; addr[i] = 32'h0; wdata[i] = 32'h0;
      busy_due[i] = 0; exp_rdata[i] = 32'h0; exp_rdata_known[i] = 1'b1;
    end
    #2;
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b0;
    wait_n(3);
    for (int i = 0; i < NI; i++) begin
      chk("rst_ack", i, 32'(ack[i]), 32'd0);
      chk("rst_resp", i, 32'(resp[i]), 32'(SCR1_MEM_RESP_NOTRDY));
      chk("rst_rdata", i, rdata[i], 32'h0);
      rst_n[i] = 1'b1;
    end
    wait_n(1);

    // Back-to-back write then read of one word.
    access(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10, 32'hDEAD_BEEF);
    chk("wr_ok", 0, 32'(resp[0]), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("b2b_ack", 0, 32'(ack[0]), 32'd1);
    access(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0);
    chk("rd_ok", 0, 32'(resp[0]), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("rd_dead", 0, rdata[0], 32'hDEAD_BEEF);

    // Byte write into a cleared word, word and upper-half readback.
    access(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0);
    access(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h11, 32'h0000_00A5);
    access(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0);
    chk("rd_byte", 0, rdata[0], 32'h0000_A500);
    access(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h12, 32'h0);
    chk("rd_hw", 0, rdata[0], 32'h0);

    // Misaligned accesses error out and leave RAM intact.
    access(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h00, 32'h1234_5678);
    access(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h13, 32'h0);
    chk("hw_mis", 0, 32'(resp[0]), 32'(SCR1_MEM_RESP_RDY_ER));
    chk("er_rdata", 0, rdata[0], 32'h0);
    access(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h02, 32'hFFFF_FFFF);
    chk("w_mis", 0, 32'(resp[0]), 32'(SCR1_MEM_RESP_RDY_ER));
    access(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h00, 32'h0);
    chk("rd_keep", 0, rdata[0], 32'h1234_5678);
    wait_n(1);
    chk("pulse", 0, 32'(resp[0]), 32'(SCR1_MEM_RESP_NOTRDY));

    // Fill the random-test regions so every read there has known data.
    for (int w = 0; w < 16; w++) begin
      access(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h100 + 32'(4 * w), $urandom);
      access(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h1000 + 32'(4 * w), $urandom);
    end
    for (int w = 0; w < 8; w++) begin
      access(2, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h200 + 32'(4 * w), $urandom);
      wait_n(3);
    end
    saved_word = {mm[key_of(2, 32'h203)], mm[key_of(2, 32'h202)], mm[key_of(2, 32'h201)], mm[key_of(2, 32'h200)]};

    // Range limits of the small, offset instance.
    access(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h1040, 32'h0);
    chk("above", 1, 32'(resp[1]), 32'(SCR1_MEM_RESP_RDY_ER));
    access(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0FFC, 32'h0);
    chk("below", 1, 32'(resp[1]), 32'(SCR1_MEM_RESP_RDY_ER));
    access(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h103C, 32'h0);
    chk("top", 1, 32'(resp[1]), 32'(SCR1_MEM_RESP_RDY_OK));
    wait_n(1);

    // Three wait states, request held high while stalled.
    req[2] = 1'b1; cmd[2] = SCR1_MEM_CMD_RD; wid[2] = SCR1_MEM_WIDTH_WORD; addr[2] = 32'h200;
    cyc();
    chk("lat_ack1", 2, 32'(ack[2]), 32'd0);
    cyc();
    chk("lat_ack2", 2, 32'(ack[2]), 32'd0);
    cyc();
    chk("lat_ack3", 2, 32'(ack[2]), 32'd0);
    cyc();
    chk("lat_resp", 2, 32'(resp[2]), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("lat_data", 2, rdata[2], saved_word);
    req[2] = 1'b0;
    cyc();
    chk("lat_pulse", 2, 32'(resp[2]), 32'(SCR1_MEM_RESP_NOTRDY));

    // Reset in the middle of a delayed write drops it.
    access(2, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h200, 32'hCAFE_F00D);
    cyc();
    rst_n[2] = 1'b0;
    #1;
    chk("mid_rst_ack", 2, 32'(ack[2]), 32'd0);
    chk("mid_rst_resp", 2, 32'(resp[2]), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("mid_rst_rdata", 2, rdata[2], 32'h0);
    purge(2);
    wait_n(2);
    rst_n[2] = 1'b1;
    wait_n(4);
    access(2, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h200, 32'h0);
    wait_n(3);
    chk("rst_keep", 2, rdata[2], saved_word);

    // Random traffic on all instances, including requests during stalls.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NI; i++) begin
        req[i]   = ($urandom_range(0, 9) < 7);
        cmd[i]   = ($urandom_range(0, 1) == 1) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
        wid[i]   = type_scr1_mem_width_e'(2'(($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2)));
        addr[i]  = rand_addr(i);
        wdata[i] = $urandom;
      end
      cyc();
    end
    for (int i = 0; i < NI; i++) req[i] = 1'b0;
    wait_n(6);
    chk("drain", 0, 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
